// File: rtl/i2c_axi_pkg.sv
// ============================================================================
// Module   : i2c_axi_pkg
// Purpose  : AXI IIC register map, AXI response codes and master FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package i2c_axi_pkg;

    localparam logic [31:0] REG_ISR     = 32'h0000_0020;
    localparam logic [31:0] REG_CR      = 32'h0000_0100;
    localparam logic [31:0] REG_SR      = 32'h0000_0104;
    localparam logic [31:0] REG_TXFIFO  = 32'h0000_0108;
    localparam logic [31:0] REG_RXFIFO  = 32'h0000_010C;
    localparam logic [31:0] REG_RX_PIRQ = 32'h0000_0120;
    localparam logic [31:0] REG_GPO     = 32'h0000_0124;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_AW_W = 3'd1,
        S_WR_B    = 3'd2,
        S_RD_AR   = 3'd3,
        S_RD_R    = 3'd4,
        S_DONE    = 3'd5
    } axi_state_e;

    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_axi_lite_master.sv
// ============================================================================
// Module   : i2c_axi_lite_master
// Purpose  : Turns sequencer wr/rd request pulses into single AXI4-Lite
//            transactions, with a completion timeout and error reporting.
// Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_axi_lite_master
    import i2c_axi_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        seq_axi_wr_req,
    input  logic                        seq_axi_rd_req,
    input  logic [AXI_ADDR_WIDTH-1:0]   seq_axi_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   seq_axi_wdata,
    output logic                        seq_axi_ack,
    output logic [AXI_DATA_WIDTH-1:0]   seq_axi_rdata,
    output logic                        seq_axi_err,
    output logic                        timeout_sticky,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                  m_axi_awprot,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LIMIT =
        TIMER_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    axi_state_e         state;
    logic [TIMER_W-1:0] timer;
    logic               busy;
    logic               expire;
    logic               final_hs;

    assign busy     = (state == S_WR_AW_W) || (state == S_WR_B) ||
                      (state == S_RD_AR)   || (state == S_RD_R);
    assign expire   = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LIMIT);
    // A B/R beat arriving on the expiry cycle still completes normally.
    assign final_hs = ((state == S_WR_B) && m_axi_bvalid) ||
                      ((state == S_RD_R) && m_axi_rvalid);

    assign m_axi_awprot = 3'b000;
    assign m_axi_wstrb  = '1;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state          <= S_IDLE;
            timer          <= '0;
            m_axi_awaddr   <= '0;
            m_axi_awvalid  <= 1'b0;
            m_axi_wdata    <= '0;
            m_axi_wvalid   <= 1'b0;
            m_axi_bready   <= 1'b0;
            m_axi_araddr   <= '0;
            m_axi_arvalid  <= 1'b0;
            m_axi_rready   <= 1'b0;
            seq_axi_ack    <= 1'b0;
            seq_axi_err    <= 1'b0;
            seq_axi_rdata  <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            seq_axi_ack <= 1'b0;
            if (busy) begin
                timer <= timer + TIMER_W'(1);
            end
            if (busy && expire && !final_hs) begin
                m_axi_awvalid  <= 1'b0;
                m_axi_wvalid   <= 1'b0;
                m_axi_bready   <= 1'b0;
                m_axi_arvalid  <= 1'b0;
                m_axi_rready   <= 1'b0;
                seq_axi_ack    <= 1'b1;
                seq_axi_err    <= 1'b1;
                timeout_sticky <= 1'b1;
                state          <= S_DONE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (seq_axi_wr_req) begin
                            m_axi_awaddr  <= seq_axi_addr;
                            m_axi_wdata   <= seq_axi_wdata;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            timer         <= '0;
                            state         <= S_WR_AW_W;
                        end else if (seq_axi_rd_req) begin
                            m_axi_araddr  <= seq_axi_addr;
                            m_axi_arvalid <= 1'b1;
                            timer         <= '0;
                            state         <= S_RD_AR;
                        end
                    end
                    S_WR_AW_W: begin
                        // A low valid doubles as the "channel done" flag.
                        if (m_axi_awready) begin
                            m_axi_awvalid <= 1'b0;
                        end
                        if (m_axi_wready) begin
                            m_axi_wvalid <= 1'b0;
                        end
                        if ((!m_axi_awvalid || m_axi_awready) &&
                            (!m_axi_wvalid  || m_axi_wready)) begin
                            m_axi_bready <= 1'b1;
                            state        <= S_WR_B;
                        end
                    end
                    S_WR_B: begin
                        if (m_axi_bvalid) begin
                            m_axi_bready <= 1'b0;
                            seq_axi_err  <= resp_is_err(m_axi_bresp);
                            seq_axi_ack  <= 1'b1;
                            state        <= S_DONE;
                        end
                    end
                    S_RD_AR: begin
                        if (m_axi_arready) begin
                            m_axi_arvalid <= 1'b0;
                            m_axi_rready  <= 1'b1;
                            state         <= S_RD_R;
                        end
                    end
                    S_RD_R: begin
                        if (m_axi_rvalid) begin
                            m_axi_rready  <= 1'b0;
                            seq_axi_rdata <= m_axi_rdata;
                            seq_axi_err   <= resp_is_err(m_axi_rresp);
                            seq_axi_ack   <= 1'b1;
                            state         <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        seq_axi_err <= 1'b0;
                        state       <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_axi_lite_master.sv
// ============================================================================
// Module   : tb_i2c_axi_lite_master
// Purpose  : Directed bench with a latency/response model and a delay-scripted
//            AXI4-Lite slave for i2c_axi_lite_master.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_i2c_axi_lite_master;
    import i2c_axi_pkg::*;

    localparam int T = 16;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        wr_req = 1'b0, rd_req = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        seq_axi_ack, seq_axi_err, timeout_sticky;
    logic [31:0] seq_axi_rdata;
    logic [31:0] awaddr, wdata, araddr, s_rdata;
    logic [2:0]  awprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 aclk = ~aclk;

    i2c_axi_lite_master #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(T)
    ) dut (
        .aclk(aclk), .areset(areset),
        .seq_axi_wr_req(wr_req), .seq_axi_rd_req(rd_req),
        .seq_axi_addr(req_addr), .seq_axi_wdata(req_wdata),
        .seq_axi_ack(seq_axi_ack), .seq_axi_rdata(seq_axi_rdata),
        .seq_axi_err(seq_axi_err), .timeout_sticky(timeout_sticky),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_rdata(s_rdata),
        .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
    );

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Slave: each ready/valid comes after a configured number of cycles.
    int          cfg_da = 0, cfg_dw = 0, cfg_db = 0, cfg_dr = 0;
    logic [1:0]  cfg_resp = RESP_OKAY;
    logic [31:0] cfg_rdata = '0;
    int          aw_wait, w_wait, ar_wait, b_wait, r_wait;
    bit          aw_got, w_got, ar_got;

    assign awready = awvalid && (aw_wait >= cfg_da);
    assign wready  = wvalid  && (w_wait  >= cfg_dw);
    assign arready = arvalid && (ar_wait >= cfg_da);
    assign bvalid  = aw_got && w_got && (b_wait >= cfg_db);
    assign rvalid  = ar_got && (r_wait >= cfg_dr);
    assign bresp   = bvalid ? cfg_resp : 2'b00;
    assign rresp   = rvalid ? cfg_resp : 2'b00;
    assign s_rdata = rvalid ? cfg_rdata : 32'h0;

    always @(posedge aclk or posedge areset) begin
        if (areset || seq_axi_ack) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
        end else begin
            aw_wait <= (awvalid && !awready) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid  && !wready)  ? w_wait + 1  : 0;
            ar_wait <= (arvalid && !arready) ? ar_wait + 1 : 0;
            if (awvalid && awready) aw_got <= 1'b1;
            if (wvalid && wready)   w_got  <= 1'b1;
            if (arvalid && arready) ar_got <= 1'b1;
            if (bvalid && bready) begin
                aw_got <= 1'b0; w_got <= 1'b0; b_wait <= 0;
            end else if (aw_got && w_got) begin
                b_wait <= b_wait + 1;
            end
            if (rvalid && rready) begin
                ar_got <= 1'b0; r_wait <= 0;
            end else if (ar_got) begin
                r_wait <= r_wait + 1;
            end
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: each request predicts its ack cycle, error flag and read data.
    typedef struct {
        int          cyc;
        bit          err;
        bit          to;
        bit          upd;
        bit          is_wr;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    bit          ea;
    logic [31:0] model_rdata = '0;
    bit          model_sticky = 1'b0;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    int          n_aw, n_w, n_b, n_ar, n_r, n_arhi, last_arhi;
    int          last_ack_cyc = -1, req_cyc = 0;
    bit          last_err;
    bit          p_aw, p_w, p_ar, p_awhs, p_whs, p_arhs;
    logic [31:0] p_awaddr, p_wdata, p_araddr;

    always @(negedge aclk) begin
        if (areset) begin
            q.delete();
            model_rdata = '0; model_sticky = 1'b0;
            n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_arhi = 0;
            p_aw = 0; p_w = 0; p_ar = 0; p_awhs = 0; p_whs = 0; p_arhs = 0;
        end else begin
            ea = (q.size() > 0) && (q[0].cyc == cyc);
            chk("ack", seq_axi_ack, ea);
            if (seq_axi_ack) begin
                last_ack_cyc = cyc;
                last_err = seq_axi_err;
            end
            if (awvalid && awready) begin
                n_aw++;
                chk("awaddr", {awprot, awaddr}, {3'b000, cur_addr});
            end
            if (wvalid && wready) begin
                n_w++;
                chk("wdata_wstrb", {wstrb, wdata}, {4'hF, cur_wdata});
            end
            if (arvalid && arready) begin
                n_ar++;
                chk("araddr", araddr, cur_addr);
            end
            if (bvalid && bready) n_b++;
            if (rvalid && rready) n_r++;
            if (arvalid) n_arhi++;
            if (p_aw && !ea) chk("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (p_w && !ea)  chk("w_stable", {wvalid, wdata}, {1'b1, p_wdata});
            if (p_ar && !ea) chk("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
            if (p_awhs) chk("aw_drop", awvalid, 1'b0);
            if (p_whs)  chk("w_drop", wvalid, 1'b0);
            if (p_arhs) chk("ar_drop", arvalid, 1'b0);
            if (ea) begin
                e = q.pop_front();
                chk("err", seq_axi_err, e.err);
                chk("bus_idle_at_ack", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
                if (!e.to)
                    chk("hs_counts", {4'(n_aw), 4'(n_w), 4'(n_b), 4'(n_ar), 4'(n_r)},
                        e.is_wr ? 20'h11100 : 20'h00011);
                if (e.upd) model_rdata = e.rdata;
                if (e.to) model_sticky = 1'b1;
                last_arhi = n_arhi;
                n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0; n_arhi = 0;
            end
            chk("rdata", seq_axi_rdata, model_rdata);
            chk("sticky", timeout_sticky, model_sticky);
            p_aw = awvalid && !awready; p_awhs = awvalid && awready; p_awaddr = awaddr;
            p_w  = wvalid && !wready;   p_whs  = wvalid && wready;   p_wdata  = wdata;
            p_ar = arvalid && !arready; p_arhs = arvalid && arready; p_araddr = araddr;
        end
    end

    // Write: d1/d2 = AW/W ready delay, d3 = B delay. Read: d1 = AR delay, d3 = R delay.
    task automatic issue(input bit wr, input bit rd, input logic [31:0] addr,
                         input logic [31:0] data, input int d1, input int d2,
                         input int d3, input logic [1:0] resp, input logic [31:0] sdata);
        exp_t x;
        int   fin;
        @(negedge aclk);
        cfg_da = d1; cfg_dw = d2; cfg_db = d3; cfg_dr = d3;
        cfg_resp = resp; cfg_rdata = sdata;
        cur_addr = addr; cur_wdata = data;
        req_cyc = cyc;
        wr_req = wr; rd_req = rd; req_addr = addr; req_wdata = data;
        fin = wr ? cyc + 2 + ((d1 > d2) ? d1 : d2) + d3 : cyc + 2 + d1 + d3;
        x.is_wr = wr;
        x.rdata = sdata;
        if (fin > cyc + T) begin
            x.cyc = cyc + T + 1; x.err = 1'b1; x.to = 1'b1; x.upd = 1'b0;
        end else begin
            x.cyc = fin + 1; x.err = (resp != RESP_OKAY); x.to = 1'b0; x.upd = !wr;
        end
        q.push_back(x);
        @(negedge aclk);
        wr_req = 1'b0; rd_req = 1'b0;
        while (cyc <= x.cyc) @(negedge aclk);
    endtask

    task automatic chk_quiet(input string name);
        chk(name, {awvalid, wvalid, bready, arvalid, rready, seq_axi_ack,
                   seq_axi_err, timeout_sticky}, 8'h00);
        chk({name, "_rdata"}, seq_axi_rdata, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge aclk);
        chk_quiet("reset_state");
        areset = 1'b0;
        @(negedge aclk);

        issue(1, 0, REG_CR, 32'h0000_000D, 0, 0, 0, RESP_OKAY, 32'h0);
        chk("wr_latency", last_ack_cyc - req_cyc, 3);
        chk("wr_err", last_err, 1'b0);

        issue(0, 1, REG_SR, 32'h0, 0, 0, 5, RESP_OKAY, 32'h0000_00C4);
        chk("rd_latency", last_ack_cyc - req_cyc, 8);
        chk("rd_data", seq_axi_rdata, 32'h0000_00C4);

        issue(1, 0, REG_TXFIFO, 32'h0000_0055, 0, 0, 0, RESP_OKAY, 32'h0);
        chk("rdata_held_by_write", seq_axi_rdata, 32'h0000_00C4);

        issue(1, 0, REG_TXFIFO, 32'h0000_01A6, 4, 0, 2, RESP_OKAY, 32'h0);
        chk("skew_aw_latency", last_ack_cyc - req_cyc, 9);
        issue(1, 0, REG_GPO, 32'h0000_0003, 0, 4, 1, RESP_OKAY, 32'h0);

        issue(0, 1, REG_RXFIFO, 32'h0, 1, 0, 2, RESP_SLVERR, 32'h0000_00A5);
        chk("slverr_err", last_err, 1'b1);
        chk("slverr_data", seq_axi_rdata, 32'h0000_00A5);
        issue(0, 1, REG_ISR, 32'h0, 0, 0, 0, RESP_OKAY, 32'h0000_003C);
        chk("okay_after_err", last_err, 1'b0);
        issue(1, 0, REG_RX_PIRQ, 32'h0000_000F, 0, 0, 0, RESP_DECERR, 32'h0);
        chk("decerr_write", last_err, 1'b1);

        issue(0, 1, REG_SR, 32'h0, 4, 0, 10, RESP_OKAY, 32'h0000_0099);
        chk("edge_hs_latency", last_ack_cyc - req_cyc, 17);
        chk("edge_hs_no_timeout", {last_err, timeout_sticky}, 2'b00);
        chk("edge_hs_data", seq_axi_rdata, 32'h0000_0099);

        issue(0, 1, REG_SR, 32'h0, 4, 0, 11, RESP_OKAY, 32'h0000_0011);
        chk("edge_to_err", {last_err, timeout_sticky}, 2'b11);
        chk("edge_to_data_kept", seq_axi_rdata, 32'h0000_0099);

        issue(0, 1, REG_SR, 32'h0, 1000, 0, 0, RESP_OKAY, 32'h0000_0077);
        chk("to_latency", last_ack_cyc - req_cyc, 17);
        chk("to_arvalid_cycles", last_arhi, 16);
        chk("to_data_kept", seq_axi_rdata, 32'h0000_0099);
        repeat (3) @(negedge aclk);
        chk("sticky_held", timeout_sticky, 1'b1);

        // Abandon a write stuck in the B phase with an asynchronous reset.
        @(negedge aclk);
        cfg_da = 0; cfg_dw = 0; cfg_db = 1000; cur_addr = REG_GPO; cur_wdata = 32'h5;
        wr_req = 1'b1; req_addr = REG_GPO; req_wdata = 32'h5;
        @(negedge aclk);
        wr_req = 1'b0;
        repeat (2) @(negedge aclk);
        chk("in_wr_b", {bready, seq_axi_ack}, 2'b10);
        #2 areset = 1'b1;
        #1 chk_quiet("async_reset");
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        issue(1, 0, REG_CR, 32'h0000_0001, 0, 0, 0, RESP_OKAY, 32'h0);
        chk("post_reset_write", last_ack_cyc - req_cyc, 3);
        issue(1, 1, REG_TXFIFO, 32'h0000_00AB, 1, 2, 0, RESP_OKAY, 32'h0000_1234);
        chk("wr_rd_as_write", seq_axi_rdata, 32'h0);

        repeat (3) @(negedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
